mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Parametrised multi-cycle MIPS control unit for the next-generation core: drives the same datapath control set as the current controller, plus memory wait-state handshake, bus timeout, `bne`/`andi`/`ori`/`slti`/`j` support, illegal-opcode trap and a retired-instruction counter. Sits between the instruction register fields and the datapath/memory port inside the `mips` top.

## Interface
- `MEM_HANDSHAKE`, default 1, meaning: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `TIMEOUT`, default 15, meaning: max wait cycles per memory access before bus error (1..255).
- `CNT_W`, default 32, meaning: width of `retired`.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `opcode` in 6: instr[31:26].
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access complete this cycle.
- `mem_req` out 1: memory access active.
- `mem_write` out 1: store strobe.
- `iord` out 1: 0 = PC address, 1 = ALUOut address.
- `ir_write` out 1: load instruction register.
- `pc_en` out 1: PC load enable.
- `pc_src` out 2: 00 ALUResult, 01 ALUOut, 10 jump target.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- `imm_zext` out 1: zero-extend immediate (andi/ori).
- `alu_control` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = memory data.
- `reg_write` out 1: register file write.
- `illegal` out 1: sticky, unsupported opcode/funct.
- `bus_err` out 1: sticky, memory timeout.
- `retired` out CNT_W: instructions completed.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BRANCH, JUMP, TRAP.
- Outputs Moore-decoded from state, except `pc_en = pc_write | (branch & (zero ^ is_bne))`, and `ir_write`/`pc_write` in FETCH gated by effective ready. All unlisted outputs 0 (`alu_control` 010).
- Effective ready `rdy = MEM_HANDSHAKE ? mem_ready : 1`.
- FETCH: mem_req, iord=0, src_a=0, src_b=01, add, pc_src=00; on rdy: ir_write, pc_write, -> DECODE; else hold.
- DECODE: src_a=0, src_b=11, add (branch target). Opcode dispatch: 100011/101011 -> MEMADR; 000000 -> RTEXE; 000100/000101 -> BRANCH; 001000/001100/001101/001010 -> IEXE; 000010 -> JUMP; other -> TRAP.
- MEMADR: src_a=1, src_b=10, add; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req, iord=1; on rdy -> MEMWB. MEMWB: reg_write, mem_to_reg, reg_dst=0 -> FETCH.
- MEMWR: mem_req, mem_write, iord=1; on rdy -> FETCH. `mem_write` stays high until rdy.
- RTEXE: src_a=1, src_b=00, alu_control by funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other -> TRAP next instead of RTWB) -> RTWB. RTWB: reg_write, reg_dst=1 -> FETCH.
- IEXE: src_a=1, src_b=10, imm_zext for andi/ori; addi add, andi and, ori or, slti slt -> IWB. IWB: reg_write, reg_dst=0 -> FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, branch=1; bne inverts zero -> FETCH.
- JUMP: pc_src=10, pc_write -> FETCH.
- TRAP: all strobes 0, holds until reset; `illegal` set on entry.
- Timeout: wait counter (8 bit) clears on entering any memory state and on rdy; increments each non-ready cycle; when it reaches TIMEOUT with no rdy -> TRAP, `bus_err`=1. Unused when MEM_HANDSHAKE=0.
- `retired` increments (wrapping modulo 2^CNT_W) on the last-state-to-FETCH transition of each instruction.

## Timing
- Reset (reset=0 at edge): state=FETCH, wait counter 0, retired 0, illegal 0, bus_err 0. Reset overrides all, including mid-wait and TRAP.
- Zero-wait cycles: lw 5, sw 4, R-type 4, I-ALU 4, beq/bne 3, j 3. Each memory wait cycle adds 1.
- `mem_ready` sampled only in FETCH/MEMRD/MEMWR; ignored elsewhere.
- rdy in the same cycle counter equals TIMEOUT: access completes, no error.

## Test plan
- Reset, MEM_HANDSHAKE=1, mem_ready=1: lw (100011) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB in 5 cycles, retired=1, reg_write only in cycle 5.
- sw with mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, iord=1, total 7 cycles, no bus_err.
- beq zero=1 -> pc_en=1 in BRANCH; bne zero=1 -> pc_en=0; bne zero=0 -> pc_en=1, pc_src=01.
- ori -> imm_zext=1, alu_control=001 in IEXE; R-type funct 101010 -> alu_control=111, RTWB reg_dst=1.
- opcode 111111 -> TRAP after DECODE, illegal=1, all strobes 0 until reset=0, then FETCH, illegal=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, bus_err=1, retired unchanged.

Source files
------------

// File: rtl/mips_mc_controller_if.sv
// Memory-port handshake between the multi-cycle controller and the memory.
// The controller is the master: it raises mem_req, steers the address with iord
// and strobes mem_write. The memory answers with mem_ready.
interface mips_mc_controller_if;
  logic mem_req;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit.
// Moore-decoded datapath controls, with two exceptions:
//   - ir_write and pc_write in FETCH are gated by memory ready.
//   - pc_en also folds in the branch condition.
// Also provides a wait-state timeout, a sticky illegal-instruction trap and a
// retired-instruction counter.
module mips_mc_controller #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 15,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  mips_mc_controller_if.master  bus,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  imm_zext,
  output logic [2:0]            alu_control,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q, bus_err_q;
  logic             rdy, pc_write, branch, in_mem, illegal_set, timeout_hit, retire;

  // With the handshake disabled every access completes in its first cycle.
  assign rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // Next-state and control decode; every output gets a safe default first.
  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_write = 1'b0;
    bus.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_control   = 3'b010;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    in_mem        = 1'b0;
    illegal_set   = 1'b0;
    timeout_hit   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        in_mem      = 1'b1;
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == TO_LIMIT) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_RTYPE:                         state_d = S_RTEXE;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXE;
          OP_J:                             state_d = S_JUMP;
          default: begin
            illegal_set = 1'b1;
            state_d     = S_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_SW) state_d = S_MEMWR;
        else                 state_d = S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        in_mem      = 1'b1;
        if (rdy) begin
          state_d = S_MEMWB;
        end else if (wait_q == TO_LIMIT) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        in_mem        = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
        end else if (wait_q == TO_LIMIT) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_RTEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        state_d   = S_RTWB;
        case (funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default: begin
            illegal_set = 1'b1;
            state_d     = S_TRAP;
          end
        endcase
      end
      S_RTWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
        case (opcode)
          OP_ANDI: begin alu_control = 3'b000; imm_zext = 1'b1; end
          OP_ORI:  begin alu_control = 3'b001; imm_zext = 1'b1; end
          OP_SLTI: alu_control = 3'b111;
          default: alu_control = 3'b010;
        endcase
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b00;
        alu_control = 3'b110;
        pc_src      = 2'b01;
        branch      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // bne takes the branch when zero is clear; beq when it is set.
  assign pc_en       = pc_write | (branch & (zero ^ (opcode == OP_BNE)));
  // The wait count only runs while a memory access is stalled.
  assign wait_d      = (in_mem && !rdy) ? (wait_q + 8'd1) : 8'd0;
  assign retire      = (state_q != S_FETCH) && (state_d == S_FETCH);
  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign retired     = retired_q;

  // State, wait counter, sticky flags and retired counter; reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retire ? (retired_q + CNT_W'(1)) : retired_q;
      illegal_q <= illegal_q | illegal_set;
      bus_err_q <= bus_err_q | timeout_hit;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: table of instructions plus hand-written
// trap, timeout and no-handshake sequences.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero;

  // main DUT: handshake on, TIMEOUT=4
  mips_mc_controller_if bus ();
  logic        ir_write, pc_en, alu_src_a, imm_zext, reg_dst, mem_to_reg, reg_write, illegal, bus_err;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_control;
  logic [31:0] retired;

  mips_mc_controller #(.MEM_HANDSHAKE(1), .TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .bus(bus),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_control(alu_control),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .retired(retired)
  );

  // second DUT: handshake off, mem_ready held low
  mips_mc_controller_if bus0 ();
  logic       h0_ir_write, h0_pc_en, h0_alu_src_a, h0_imm_zext, h0_reg_dst, h0_mem_to_reg;
  logic       h0_reg_write, h0_illegal, h0_bus_err;
  logic [1:0] h0_pc_src, h0_alu_src_b;
  logic [2:0] h0_alu_control;
  logic [7:0] h0_retired;

  mips_mc_controller #(.MEM_HANDSHAKE(0), .TIMEOUT(15), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .bus(bus0),
    .ir_write(h0_ir_write), .pc_en(h0_pc_en), .pc_src(h0_pc_src), .alu_src_a(h0_alu_src_a),
    .alu_src_b(h0_alu_src_b), .imm_zext(h0_imm_zext), .alu_control(h0_alu_control),
    .reg_dst(h0_reg_dst), .mem_to_reg(h0_mem_to_reg), .reg_write(h0_reg_write),
    .illegal(h0_illegal), .bus_err(h0_bus_err), .retired(h0_retired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         wat;   // cycle index where mem_ready goes low
    int         wn;    // number of low cycles
    int         cyc;   // expected instruction length
    int         rw;    // cycles with reg_write
    int         mw;    // cycles with mem_write
    int         io;    // cycles with iord
    logic [2:0] alu;   // execute-cycle values
    logic [1:0] srcb;
    logic       zx;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       dst;   // last-cycle values
    logic       m2r;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int wat, input int wn, input int cyc,
                              input int rw, input int mw, input int io, input logic [2:0] alu,
                              input logic [1:0] srcb, input logic zx, input logic pcen,
                              input logic [1:0] pcsrc, input logic dst, input logic m2r);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.z = z; v.wat = wat; v.wn = wn; v.cyc = cyc;
    v.rw = rw; v.mw = mw; v.io = io; v.alu = alu; v.srcb = srcb; v.zx = zx; v.pcen = pcen;
    v.pcsrc = pcsrc; v.dst = dst; v.m2r = m2r;
    return v;
  endfunction

  // results of the last run_instr
  int         r_cyc, r_rw, r_mw, r_io;
  logic [2:0] r_alu;
  logic [1:0] r_srcb, r_pcsrc;
  logic       r_zx, r_pcen, r_dst, r_m2r;

  // Runs one instruction starting in FETCH (called in the low clock phase);
  // returns in the low phase of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wat, input int wn, input int e);
    int   k;
    logic left;
    opcode = op; funct = fn; zero = z;
    k = 0; left = 1'b0;
    r_rw = 0; r_mw = 0; r_io = 0;
    r_alu = 3'bx; r_srcb = 2'bx; r_zx = 1'bx; r_pcen = 1'bx; r_pcsrc = 2'bx;
    forever begin
      bus.mem_ready = !(k >= wat && k < wat + wn);
      #1;
      if (bus.mem_req && !bus.iord) begin
        if (left) break;
      end else begin
        left = 1'b1;
      end
      if (reg_write)     r_rw++;
      if (bus.mem_write) r_mw++;
      if (bus.iord)      r_io++;
      if (k == e) begin
        r_alu = alu_control; r_srcb = alu_src_b; r_zx = imm_zext;
        r_pcen = pc_en; r_pcsrc = pc_src;
      end
      r_dst = reg_dst; r_m2r = mem_to_reg;
      k++;
      if (k >= 40) break;
      @(negedge clk);
    end
    r_cyc = k;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[19];
  int   exp_ret;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk("lw",      6'b100011, 6'b000000, 1'b0, 0, 0, 5, 1, 0, 1, 3'b010, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[1]  = mk("lw_wait", 6'b100011, 6'b000000, 1'b0, 3, 4, 9, 1, 0, 5, 3'b010, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    tbl[2]  = mk("sw",      6'b101011, 6'b000000, 1'b0, 0, 0, 4, 0, 1, 1, 3'b010, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[3]  = mk("sw_wait", 6'b101011, 6'b000000, 1'b0, 3, 3, 7, 0, 4, 4, 3'b010, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[4]  = mk("add",     6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 0, 0, 3'b010, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[5]  = mk("sub",     6'b000000, 6'b100010, 1'b0, 0, 0, 4, 1, 0, 0, 3'b110, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[6]  = mk("and",     6'b000000, 6'b100100, 1'b0, 0, 0, 4, 1, 0, 0, 3'b000, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[7]  = mk("or",      6'b000000, 6'b100101, 1'b0, 0, 0, 4, 1, 0, 0, 3'b001, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[8]  = mk("slt",     6'b000000, 6'b101010, 1'b0, 0, 0, 4, 1, 0, 0, 3'b111, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tbl[9]  = mk("addi",    6'b001000, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 0, 3'b010, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[10] = mk("andi",    6'b001100, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 0, 3'b000, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[11] = mk("ori",     6'b001101, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 0, 3'b001, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[12] = mk("slti",    6'b001010, 6'b000000, 1'b0, 0, 0, 4, 1, 0, 0, 3'b111, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tbl[13] = mk("beq_z1",  6'b000100, 6'b000000, 1'b1, 0, 0, 3, 0, 0, 0, 3'b110, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    tbl[14] = mk("beq_z0",  6'b000100, 6'b000000, 1'b0, 0, 0, 3, 0, 0, 0, 3'b110, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[15] = mk("bne_z1",  6'b000101, 6'b000000, 1'b1, 0, 0, 3, 0, 0, 0, 3'b110, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    tbl[16] = mk("bne_z0",  6'b000101, 6'b000000, 1'b0, 0, 0, 3, 0, 0, 0, 3'b110, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    tbl[17] = mk("j",       6'b000010, 6'b000000, 1'b0, 0, 0, 3, 0, 0, 0, 3'b010, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    // ready arrives exactly when the wait count equals TIMEOUT: must complete
    tbl[18] = mk("j_fwait", 6'b000010, 6'b000000, 1'b0, 0, 4, 7, 0, 0, 0, 3'b010, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);

    // reset state
    reset = 1'b0; opcode = 6'b000010; funct = 6'b000000; zero = 1'b0;
    bus.mem_ready = 1'b1; bus0.mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    check("rst_retired", retired, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_fetch",   32'({bus.mem_req, bus.iord, alu_src_b}), 32'b1001);
    check("rst_h0_ret",  32'(h0_retired), 32'd0);

    // three jumps back to back, both DUTs (the second one ignores mem_ready)
    reset = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    check("jx3_retired",    retired, 32'd3);
    check("jx3_h0_retired", 32'(h0_retired), 32'd3);

    // instruction table
    do_reset();
    exp_ret = 0;
    for (int i = 0; i < 19; i++) begin
      int e;
      e = (tbl[i].wat == 0 && tbl[i].wn > 0) ? 2 + tbl[i].wn : 2;
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].wat, tbl[i].wn, e);
      exp_ret++;
      check({tbl[i].name, "_cycles"},   32'(r_cyc), 32'(tbl[i].cyc));
      check({tbl[i].name, "_rw_cnt"},   32'(r_rw),  32'(tbl[i].rw));
      check({tbl[i].name, "_mw_cnt"},   32'(r_mw),  32'(tbl[i].mw));
      check({tbl[i].name, "_iord_cnt"}, 32'(r_io),  32'(tbl[i].io));
      check({tbl[i].name, "_alu"},      32'(r_alu), 32'(tbl[i].alu));
      check({tbl[i].name, "_src_b"},    32'(r_srcb), 32'(tbl[i].srcb));
      check({tbl[i].name, "_zext"},     32'(r_zx),  32'(tbl[i].zx));
      check({tbl[i].name, "_pc_en"},    32'(r_pcen), 32'(tbl[i].pcen));
      check({tbl[i].name, "_pc_src"},   32'(r_pcsrc), 32'(tbl[i].pcsrc));
      check({tbl[i].name, "_reg_dst"},  32'(r_dst), 32'(tbl[i].dst));
      check({tbl[i].name, "_m2r"},      32'(r_m2r), 32'(tbl[i].m2r));
      check({tbl[i].name, "_retired"},  retired, 32'(exp_ret));
      check({tbl[i].name, "_bus_err"},  32'(bus_err), 32'd0);
    end

    // illegal opcode: FETCH, DECODE, then TRAP until reset
    opcode = 6'b111111; bus.mem_ready = 1'b1;
    #1;
    @(negedge clk); #1;
    check("trap_op_dec_illegal", 32'(illegal), 32'd0);
    @(negedge clk); #1;
    check("trap_op_illegal", 32'(illegal), 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("trap_op_strobes", 32'({bus.mem_req, bus.mem_write, ir_write, pc_en, reg_write}), 32'd0);
      @(negedge clk); #1;
    end
    check("trap_op_retired", retired, 32'(exp_ret));
    reset = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("trap_rst_illegal", 32'(illegal), 32'd0);
    check("trap_rst_fetch",   32'({bus.mem_req, bus.iord}), 32'b10);
    check("trap_rst_retired", retired, 32'd0);
    reset = 1'b1;

    // illegal funct: FETCH, DECODE, RTEXE, TRAP
    opcode = 6'b000000; funct = 6'b000000;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("trap_fn_rtexe_illegal", 32'(illegal), 32'd0);
    @(negedge clk); #1;
    check("trap_fn_illegal", 32'(illegal), 32'd1);
    check("trap_fn_mem_req", 32'(bus.mem_req), 32'd0);
    do_reset(); #1;

    // FETCH timeout with TIMEOUT=4
    opcode = 6'b000010; bus.mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("to_still_fetch", 32'({bus.mem_req, bus.iord, bus_err}), 32'b100);
    @(negedge clk); #1;
    check("to_trap_mem_req", 32'(bus.mem_req), 32'd0);
    check("to_bus_err",      32'(bus_err), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("to_bus_err_sticky", 32'(bus_err), 32'd1);
    check("to_retired",        retired, 32'd0);
    bus.mem_ready = 1'b1;
    do_reset(); #1;
    check("to_rst_bus_err", 32'(bus_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
